// File: rtl/memi_read_sched_pkg.sv
// rtl/memi_read_sched_pkg.sv - shared widths, state encodings and helpers for the memi read scheduler
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 8
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef MEMI_SCHED_INIT
`define MEMI_SCHED_INIT 1'b0
`endif
`ifndef MEMI_SCHED_RUN
`define MEMI_SCHED_RUN 1'b1
`endif

package memi_read_sched_pkg;

  localparam int MEMI_ADDR_W = `MEMI_SIZE_LOG;
  localparam int MEMI_DATA_W = `INST_LEN;

  localparam logic [0:0] ST_INIT = `MEMI_SCHED_INIT;
  localparam logic [0:0] ST_RUN  = `MEMI_SCHED_RUN;

  // Width of a counter that must hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/memi_starve_arb.sv
// rtl/memi_starve_arb.sv - two-way fetch-priority arbiter with a saturating debug starvation bound
module memi_starve_arb
  import memi_read_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic f_valid,
  input  logic d_valid,
  output logic f_grant,
  output logic d_grant
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             d_wins_tie;

  // Fetch wins ties until debug has lost STARVE_LIMIT of them in a row.
  always_comb begin
    d_wins_tie = (starve_cnt == LIMIT);
    f_grant    = 1'b0;
    d_grant    = 1'b0;
    if (en) begin
      if (f_valid && d_valid) begin
        d_grant = d_wins_tie;
        f_grant = !d_wins_tie;
      end else begin
        f_grant = f_valid;
        d_grant = d_valid;
      end
    end
  end

  // Count consecutive lost ties; any debug win or idle debug restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (d_grant || !d_valid) begin
      starve_cnt <= '0;
    end else if (f_grant && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/memi_read_sched.sv
// rtl/memi_read_sched.sv - schedules the memi read port between fetch and debug with registered responses
module memi_read_sched
  import memi_read_sched_pkg::*;
#(
  parameter int ADDR_W       = MEMI_ADDR_W,
  parameter int DATA_W       = MEMI_DATA_W,
  parameter int INIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_resp_valid,
  output logic [DATA_W-1:0] f_resp_data,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic [ADDR_W-1:0] memi_addr,
  input  logic [DATA_W-1:0] memi_data
);

  localparam int INIT_W = cnt_width(INIT_CYCLES);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  logic [0:0]        state;
  logic [INIT_W-1:0] init_cnt;
  logic              run;
  logic              f_grant;
  logic              d_grant;
  logic              f_hs;
  logic              d_hs;

  assign run = (state == ST_RUN);

  memi_starve_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .f_valid(f_req_valid),
    .d_valid(d_req_valid),
    .f_grant(f_grant),
    .d_grant(d_grant)
  );

  assign f_req_ready = f_grant;
  assign d_req_ready = d_grant;
  assign f_hs        = f_req_valid & f_grant;
  assign d_hs        = d_req_valid & d_grant;

  // Fetch address is the idle default so the port never floats between owners.
  assign memi_addr = d_grant ? d_req_addr : f_req_addr;

  // Hold both requesters off for INIT_CYCLES after reset while memi initialises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == INIT_LAST) begin
        state <= ST_RUN;
      end
    end
  end

  // Capture the combinational memi read for the winner; valid pulses exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      f_resp_data  <= '0;
      d_resp_data  <= '0;
    end else begin
      f_resp_valid <= f_hs;
      d_resp_valid <= d_hs;
      if (f_hs) begin
        f_resp_data <= memi_data;
      end
      if (d_hs) begin
        d_resp_data <= memi_data;
      end
    end
  end

endmodule

// File: tb/tb_memi_read_sched.sv
// tb/tb_memi_read_sched.sv - directed bench for the memi read scheduler
module tb_memi_read_sched;

  logic        clk;
  logic        rst;
  logic        f_req_valid;
  logic [7:0]  f_req_addr;
  logic        d_req_valid;
  logic [7:0]  d_req_addr;

  logic        a_f_ready, a_f_rv, a_d_ready, a_d_rv;
  logic [31:0] a_f_rd, a_d_rd, a_mdata;
  logic [7:0]  a_maddr;
  logic        b_f_ready, b_f_rv, b_d_ready, b_d_rv;
  logic [31:0] b_f_rd, b_d_rd, b_mdata;
  logic [7:0]  b_maddr;

  logic [31:0] mem [0:255];
  int total;
  int bad;

  assign a_mdata = mem[a_maddr];
  assign b_mdata = mem[b_maddr];

  memi_read_sched #(.ADDR_W(8), .DATA_W(32), .INIT_CYCLES(2), .STARVE_LIMIT(3)) dut_a (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(a_f_ready),
    .f_resp_valid(a_f_rv), .f_resp_data(a_f_rd),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(a_d_ready),
    .d_resp_valid(a_d_rv), .d_resp_data(a_d_rd),
    .memi_addr(a_maddr), .memi_data(a_mdata)
  );

  memi_read_sched #(.ADDR_W(8), .DATA_W(32), .INIT_CYCLES(2), .STARVE_LIMIT(0)) dut_b (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(b_f_ready),
    .f_resp_valid(b_f_rv), .f_resp_data(b_f_rd),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(b_d_ready),
    .d_resp_valid(b_d_rv), .d_resp_data(b_d_rd),
    .memi_addr(b_maddr), .memi_data(b_mdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_req_valid = 1'b1; f_req_addr = 8'd3; d_req_valid = 1'b0; d_req_addr = 8'd0;
    step(); step(); #1;
    total++; if (a_f_rv !== 1'b0) begin bad++; $display("FAIL reset_f_rv got=%b exp=0", a_f_rv); end
    total++; if (a_d_rv !== 1'b0) begin bad++; $display("FAIL reset_d_rv got=%b exp=0", a_d_rv); end
    total++; if (a_f_rd !== 32'h0) begin bad++; $display("FAIL reset_f_rd got=%h exp=0", a_f_rd); end
    total++; if (a_d_rd !== 32'h0) begin bad++; $display("FAIL reset_d_rd got=%h exp=0", a_d_rd); end
    total++; if (a_f_ready !== 1'b0) begin bad++; $display("FAIL reset_f_ready got=%b exp=0", a_f_ready); end
    step(); rst = 1'b0; #1;
    total++; if (a_f_ready !== 1'b0) begin bad++; $display("FAIL init_c1_ready got=%b exp=0", a_f_ready); end
    step(); #1;
    total++; if (a_f_ready !== 1'b0) begin bad++; $display("FAIL init_c2_ready got=%b exp=0", a_f_ready); end
    step(); #1;
    total++; if (a_f_ready !== 1'b1) begin bad++; $display("FAIL init_c3_ready got=%b exp=1", a_f_ready); end
    total++; if (a_maddr !== 8'd3) begin bad++; $display("FAIL init_c3_maddr got=%h exp=03", a_maddr); end
    step(); f_req_valid = 1'b0; #1;
    total++; if (a_f_rv !== 1'b1) begin bad++; $display("FAIL init_c4_f_rv got=%b exp=1", a_f_rv); end
    total++; if (a_f_rd !== 32'h1000_0003) begin bad++; $display("FAIL init_c4_f_rd got=%h exp=10000003", a_f_rd); end
  endtask

  task automatic test_single_fetch();
    step(); f_req_valid = 1'b1; f_req_addr = 8'd5; #1;
    total++; if (a_f_ready !== 1'b1) begin bad++; $display("FAIL single_f_ready got=%b exp=1", a_f_ready); end
    total++; if (a_d_ready !== 1'b0) begin bad++; $display("FAIL single_d_ready got=%b exp=0", a_d_ready); end
    step(); f_req_valid = 1'b0; #1;
    total++; if (a_f_rv !== 1'b1) begin bad++; $display("FAIL single_f_rv got=%b exp=1", a_f_rv); end
    total++; if (a_f_rd !== 32'h0000_00A5) begin bad++; $display("FAIL single_f_rd got=%h exp=000000a5", a_f_rd); end
    total++; if (a_d_rv !== 1'b0) begin bad++; $display("FAIL single_d_rv got=%b exp=0", a_d_rv); end
    step(); #1;
    total++; if (a_f_rv !== 1'b0) begin bad++; $display("FAIL single_pulse_end got=%b exp=0", a_f_rv); end
    total++; if (a_f_rd !== 32'h0000_00A5) begin bad++; $display("FAIL single_hold got=%h exp=000000a5", a_f_rd); end
  endtask

  task automatic test_starvation();
    logic exp_d;
    logic prev_d;
    prev_d = 1'b0;
    step(); f_req_valid = 1'b1; f_req_addr = 8'd3; d_req_valid = 1'b1; d_req_addr = 8'd4;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_d = ((k % 4) == 3);
      total++; if (a_d_ready !== exp_d) begin bad++; $display("FAIL starve_d_ready k=%0d got=%b exp=%b", k, a_d_ready, exp_d); end
      total++; if (a_f_ready !== !exp_d) begin bad++; $display("FAIL starve_f_ready k=%0d got=%b exp=%b", k, a_f_ready, !exp_d); end
      total++; if (a_maddr !== (exp_d ? 8'd4 : 8'd3)) begin bad++; $display("FAIL starve_maddr k=%0d got=%h", k, a_maddr); end
      total++; if (b_d_ready !== 1'b1 || b_f_ready !== 1'b0) begin bad++; $display("FAIL limit0_grant k=%0d got d=%b f=%b exp d=1 f=0", k, b_d_ready, b_f_ready); end
      if (k > 0) begin
        total++; if (a_d_rv !== prev_d || a_f_rv !== !prev_d) begin bad++; $display("FAIL starve_resp k=%0d got d=%b f=%b exp d=%b", k, a_d_rv, a_f_rv, prev_d); end
      end
      prev_d = exp_d;
      step();
    end
    f_req_valid = 1'b0; d_req_valid = 1'b0; #1;
    total++; if (a_d_rv !== 1'b1) begin bad++; $display("FAIL starve_last_d_rv got=%b exp=1", a_d_rv); end
    total++; if (a_d_rd !== 32'h1000_0004) begin bad++; $display("FAIL starve_last_d_rd got=%h exp=10000004", a_d_rd); end
    total++; if (b_d_rd !== 32'h1000_0004) begin bad++; $display("FAIL limit0_d_rd got=%h exp=10000004", b_d_rd); end
  endtask

  task automatic test_back_to_back();
    step(); f_req_valid = 1'b1; f_req_addr = 8'd1; #1;
    total++; if (a_maddr !== 8'd1) begin bad++; $display("FAIL b2b_maddr_f got=%h exp=01", a_maddr); end
    total++; if (a_f_ready !== 1'b1) begin bad++; $display("FAIL b2b_f_ready got=%b exp=1", a_f_ready); end
    step(); f_req_valid = 1'b0; d_req_valid = 1'b1; d_req_addr = 8'd7; #1;
    total++; if (a_maddr !== 8'd7) begin bad++; $display("FAIL b2b_maddr_d got=%h exp=07", a_maddr); end
    total++; if (a_d_ready !== 1'b1) begin bad++; $display("FAIL b2b_d_ready got=%b exp=1", a_d_ready); end
    total++; if (a_f_rv !== 1'b1 || a_f_rd !== 32'h1000_0001) begin bad++; $display("FAIL b2b_f_resp got v=%b d=%h exp v=1 d=10000001", a_f_rv, a_f_rd); end
    step(); d_req_valid = 1'b0; #1;
    total++; if (a_d_rv !== 1'b1 || a_d_rd !== 32'h1000_0007) begin bad++; $display("FAIL b2b_d_resp got v=%b d=%h exp v=1 d=10000007", a_d_rv, a_d_rd); end
    total++; if (a_f_rv !== 1'b0) begin bad++; $display("FAIL b2b_f_rv_end got=%b exp=0", a_f_rv); end
  endtask

  task automatic test_mid_reset();
    step(); f_req_valid = 1'b1; f_req_addr = 8'd2; #1;
    total++; if (a_f_ready !== 1'b1) begin bad++; $display("FAIL midrst_hs_ready got=%b exp=1", a_f_ready); end
    step(); f_req_valid = 1'b0; rst = 1'b1;
    step(); rst = 1'b0; f_req_valid = 1'b1; f_req_addr = 8'd6; #1;
    total++; if (a_f_rv !== 1'b0) begin bad++; $display("FAIL midrst_f_rv got=%b exp=0", a_f_rv); end
    total++; if (a_f_rd !== 32'h0) begin bad++; $display("FAIL midrst_f_rd got=%h exp=0", a_f_rd); end
    total++; if (a_f_ready !== 1'b0) begin bad++; $display("FAIL midrst_c1_ready got=%b exp=0", a_f_ready); end
    step(); f_req_addr = 8'd2; #1;
    total++; if (a_f_ready !== 1'b0) begin bad++; $display("FAIL midrst_c2_ready got=%b exp=0", a_f_ready); end
    step(); #1;
    total++; if (a_f_ready !== 1'b1) begin bad++; $display("FAIL midrst_c3_ready got=%b exp=1", a_f_ready); end
    step(); f_req_valid = 1'b0; #1;
    total++; if (a_f_rv !== 1'b1 || a_f_rd !== 32'h1000_0002) begin bad++; $display("FAIL midrst_resp got v=%b d=%h exp v=1 d=10000002", a_f_rv, a_f_rd); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[5] = 32'h0000_00A5;
    rst = 1'b1; f_req_valid = 1'b0; f_req_addr = 8'd0; d_req_valid = 1'b0; d_req_addr = 8'd0;
    test_reset();
    test_single_fetch();
    test_starvation();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
